sram_bist: RTL and testbench
============================

# sram_bist

Synthesizable built-in self-test engine for the 16 x 8 single-port, asynchronous-read SRAM. It is the initiator side of the SRAM's address, data_in and control interface and the checker of its data_out. On start it writes a seed-derived pattern to every location and reads it back, then does the same with the complement. It reports pass/fail, an error count and the first failing location. It sits between the SRAM macro and the system status/register logic and replaces bench-only write/read/compare loops in silicon.

## Interface
- ADDR_W, 4, SRAM address width
- DATA_W, 8, SRAM word width
- DEPTH, 16, number of locations tested; must equal 2**ADDR_W

Ports:
- clk  in  1  single clock; SRAM writes on the same rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a test run; sampled on a rising edge
- seed  in  DATA_W  pattern seed; latched on the edge that accepts start
- busy  out  1  high while a run is in progress
- done  out  1  high from run completion until the next accepted start or reset
- pass  out  1  equals (error_count == 0); meaningful only while done = 1
- error_count  out  ADDR_W+2  number of miscompares in the current or last run
- first_fail_addr  out  ADDR_W  address of the first miscompare
- first_fail_phase  out  1  0 = true-pattern read, 1 = complement read
- mem_address  out  ADDR_W  SRAM address
- mem_data_in  out  DATA_W  SRAM write data
- mem_control  out  1  SRAM write enable (1 = write)
- mem_data_out  in  DATA_W  SRAM combinational read data

## Operation
- States: IDLE, WR0, RD0, WR1, RD1, DONE. An address counter `a` runs from 0 to DEPTH-1 in every active state.
- Pattern: P(a) = (seed_q + a) mod 2**DATA_W, where `a` is zero-extended. The complement pattern is ~P(a).
- IDLE or DONE with start = 1:
  - latch seed into seed_q
  - clear error_count, first_fail_addr and first_fail_phase
  - set a = 0 and enter WR0
- In IDLE or DONE, start = 0 leaves the state unchanged. start is ignored in all active states.
- WR0: mem_control = 1, mem_address = a, mem_data_in = P(a).
- WR1: same as WR0, but mem_data_in = ~P(a).
- RD0 and RD1: mem_control = 0, mem_address = a, mem_data_in = 0.
- Read check: at the rising edge ending each read cycle, mem_data_out is compared with the expected value, P(a) in RD0 and ~P(a) in RD1.
  - Any mismatch, including X/Z bits, counts as a failure.
  - On failure, error_count increments.
  - If error_count was 0, first_fail_addr and first_fail_phase are also captured.
- When a = DEPTH-1, the next edge sets a to 0 and advances WR0 -> RD0 -> WR1 -> RD1 -> DONE.
- error_count never saturates: its maximum is 2*DEPTH = 32, which fits in ADDR_W+2 bits.
- Outputs are decoded from registered state and counter only. mem_control must not glitch.

## Timing
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, pass = 1
  - error_count = 0, first_fail_addr = 0, first_fail_phase = 0
  - mem_control = 0, mem_address = 0, mem_data_in = 0
- Cycle numbering: edge E0 accepts start, and cycle n lies between edges E(n-1) and En.
  - Cycles 1-16: WR0
  - Cycles 17-32: RD0
  - Cycles 33-48: WR1
  - Cycles 49-64: RD1
- After edge E0, busy = 1. After edge E64, busy = 0 and done = 1. Each run takes exactly 4*DEPTH cycles.
- Write latency: data presented in cycle n is stored in the SRAM at En. A read of that location in any later cycle returns it within the same cycle, because the SRAM read is asynchronous.
- A reset asserted at any edge, including mid-run, forces the reset values at that edge. mem_control is low in the following cycle. The partial run's results are discarded.
- reset and start at the same edge: reset wins.
- A start accepted in DONE drops done after that edge, and busy rises at the same edge.

## Test plan
- Ideal 16x8 SRAM model, seed 0x00:
  - 16 writes of 00..0F with control high, then the reads
  - done rises after E64 with pass = 1 and error_count = 0
- SRAM data_out bit 3 stuck at 0, seed 0x00:
  - error_count = 16: addresses 8-15 fail in RD0 and 0-7 fail in RD1
  - first_fail_addr = 8, first_fail_phase = 0, pass = 0
- SRAM address bit 0 tied to 1, seed 0x00:
  - error_count = 16: all even addresses fail in both read phases
  - first_fail_addr = 0, first_fail_phase = 0
- Reset pulsed at E20 (inside RD0) with a faulty model:
  - at the next cycle busy = 0, done = 0, error_count = 0, mem_control = 0
  - a fresh start then completes normally
- start held high for the whole run:
  - run length stays 64 cycles and no restart happens while busy
  - from DONE, start with seed 0xA5 on the ideal model clears the previous error_count from the stuck-bit run
  - pass = 1 after a further 64 cycles, and the first write is 0xA5 at address 0

Source files
------------

// File: rtl/sram_bist.sv
// Built-in self-test for a 16x8 asynchronous-read SRAM: writes a seed-derived
// pattern and its complement to every location, reads each back and logs miscompares.
module sram_bist #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W+1:0] error_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic              first_fail_phase,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_control,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR0  = 3'd1,
        RD0  = 3'd2,
        WR1  = 3'd3,
        RD1  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   a, a_nxt;
    logic [DATA_W-1:0]   seed_q;
    logic [DATA_W-1:0]   pattern;
    logic [DATA_W-1:0]   expected;
    logic                last;
    logic                accept;
    logic                mismatch;
    logic                mem_control_nxt;

    assign last    = (a == ADDR_W'(DEPTH - 1));
    assign pattern = seed_q + DATA_W'(a);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a     <= '0;
        end else begin
            state <= state_nxt;
            a     <= a_nxt;
        end
    end

    // Each active state walks a through every location, then hands off.
    always_comb begin
        state_nxt = state;
        a_nxt     = a;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = WR0;
                    a_nxt     = '0;
                end
            end
            WR0: begin
                a_nxt = last ? '0 : a + 1'b1;
                if (last) state_nxt = RD0;
            end
            RD0: begin
                a_nxt = last ? '0 : a + 1'b1;
                if (last) state_nxt = WR1;
            end
            WR1: begin
                a_nxt = last ? '0 : a + 1'b1;
                if (last) state_nxt = RD1;
            end
            RD1: begin
                a_nxt = last ? '0 : a + 1'b1;
                if (last) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write enable comes straight from a flop so the SRAM never sees a decode glitch.
    assign mem_control_nxt = (state_nxt == WR0) || (state_nxt == WR1);

    // Case inequality so X/Z on the read bus is treated as a failure.
    assign expected = (state == RD1) ? ~pattern : pattern;
    assign mismatch = ((state == RD0) || (state == RD1)) && (mem_data_out !== expected);

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_control      <= 1'b0;
            seed_q           <= '0;
            error_count      <= '0;
            first_fail_addr  <= '0;
            first_fail_phase <= 1'b0;
        end else begin
            mem_control <= mem_control_nxt;
            if (accept) begin
                seed_q           <= seed;
                error_count      <= '0;
                first_fail_addr  <= '0;
                first_fail_phase <= 1'b0;
            end else if (mismatch) begin
                error_count <= error_count + 1'b1;
                if (error_count == '0) begin
                    first_fail_addr  <= a;
                    first_fail_phase <= (state == RD1);
                end
            end
        end
    end

    assign busy        = (state != IDLE) && (state != DONE);
    assign done        = (state == DONE);
    assign pass        = (error_count == '0);
    assign mem_address = a;
    assign mem_data_in = (state == WR0) ? pattern :
                         (state == WR1) ? ~pattern : '0;

endmodule

// File: tb/tb_sram_bist.sv
// Bench for sram_bist: a fault-injectable SRAM model plus a reference model that
// replays the march test on an array to predict error count and first failure.
module tb_sram_bist;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int W      = 1 + ADDR_W + DATA_W;

    logic              clk;
    logic              reset;
    logic              start;
    logic [DATA_W-1:0] seed;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W+1:0] error_count;
    logic [ADDR_W-1:0] first_fail_addr;
    logic              first_fail_phase;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_control;
    logic [DATA_W-1:0] mem_data_out;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];

    // Fault configuration: 0 ideal, 1 data_out bit fbit stuck at fval, 2 address bit fbit tied to fval
    int          mode = 0;
    logic [2:0]  fbit = 3'd0;
    logic        fval = 1'b0;
    logic [DATA_W-1:0] sram [DEPTH];
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] rd_word;

    sram_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .error_count(error_count),
        .first_fail_addr(first_fail_addr), .first_fail_phase(first_fail_phase),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_control(mem_control), .mem_data_out(mem_data_out)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model
    initial for (int i = 0; i < DEPTH; i++) sram[i] = '0;

    always_comb begin
        eff_addr = mem_address;
        if (mode == 2) eff_addr[fbit[1:0]] = fval;
        rd_word = sram[eff_addr];
        if (mode == 1) rd_word[fbit] = fval;
        mem_data_out = rd_word;
    end

    always @(posedge clk) begin
        if (mem_control) sram[eff_addr] <= mem_data_in;
    end

    // Reference model
    function automatic int model_eff(input int a, input int md, input logic [2:0] fb, input logic fv);
        int bitv;
        bitv = 1 << int'(fb[1:0]);
        if (md != 2) return a;
        return fv ? (a | bitv) : (a & ~bitv);
    endfunction

    task automatic model_run(input logic [7:0] s, input int md, input logic [2:0] fb, input logic fv,
                             output int ec, output int ffa, output int ffp);
        int m[DEPTH];
        int p, v;
        ec = 0; ffa = 0; ffp = 0;
        for (int i = 0; i < DEPTH; i++) m[i] = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < DEPTH; a++) begin
                p = (int'(s) + a) % 256;
                m[model_eff(a, md, fb, fv)] = (ph == 1) ? 255 - p : p;
            end
            for (int a = 0; a < DEPTH; a++) begin
                p = (int'(s) + a) % 256;
                if (ph == 1) p = 255 - p;
                v = m[model_eff(a, md, fb, fv)];
                if (md == 1) v = fv ? (v | (1 << int'(fb))) : (v & ~(1 << int'(fb)));
                if (v != p) begin
                    if (ec == 0) begin ffa = a; ffp = ph; end
                    ec++;
                end
            end
        end
    endtask

    // Driver tasks
    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        seed  = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Starts a run from IDLE/DONE and checks every cycle plus the final results.
    task automatic run_check(input logic [7:0] s, input int md, input logic [2:0] fb, input logic fv,
                             input bit hold, input string name);
        int ec, ffa, ffp, p, ph, a;
        logic [W-1:0] e, got;
        mode = md; fbit = fb; fval = fv;
        seed  = s;
        start = 1'b1;
        model_run(s, md, fb, fv, ec, ffa, ffp);
        exp_q.delete();
        for (int n = 0; n < 4 * DEPTH; n++) begin
            ph = n / DEPTH;
            a  = n % DEPTH;
            p  = (int'(s) + a) % 256;
            if (ph == 0)      e = {1'b1, 4'(a), 8'(p)};
            else if (ph == 2) e = {1'b1, 4'(a), 8'(255 - p)};
            else              e = {1'b0, 4'(a), 8'h00};
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        seed = 8'($urandom);
        n_cmp++;
        if (error_count !== '0 || first_fail_addr !== '0 || first_fail_phase !== 1'b0 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL %s start_clear: ec=%0d ffa=%0d ffp=%b pass=%b, expected 0 0 0 1",
                     name, error_count, first_fail_addr, first_fail_phase, pass);
        end
        for (int n = 1; n <= 4 * DEPTH; n++) begin
            e   = exp_q.pop_front();
            got = {mem_control, mem_address, mem_data_in};
            n_cmp++;
            if (got !== e || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s cycle %0d: ctrl/addr/din=%h busy=%b done=%b, expected %h busy=1 done=0",
                         name, n, got, busy, done, e);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || mem_control !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end_flags: done=%b busy=%b ctrl=%b, expected 1 0 0", name, done, busy, mem_control);
        end
        n_cmp++;
        if (error_count !== 6'(ec) || pass !== (ec == 0)) begin
            n_fail++;
            $display("FAIL %s result: ec=%0d pass=%b, expected ec=%0d pass=%b", name, error_count, pass, ec, ec == 0);
        end
        n_cmp++;
        if (first_fail_addr !== 4'(ffa) || first_fail_phase !== 1'(ffp)) begin
            n_fail++;
            $display("FAIL %s first_fail: addr=%0d phase=%b, expected addr=%0d phase=%0d",
                     name, first_fail_addr, first_fail_phase, ffa, ffp);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b done=%b pass=%b, expected 0 0 1", busy, done, pass);
        end
        n_cmp++;
        if (error_count !== '0 || first_fail_addr !== '0 || first_fail_phase !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_results: ec=%0d ffa=%0d ffp=%b, expected 0 0 0", error_count, first_fail_addr, first_fail_phase);
        end
        n_cmp++;
        if (mem_control !== 1'b0 || mem_address !== '0 || mem_data_in !== '0) begin
            n_fail++;
            $display("FAIL reset_mem: ctrl=%b addr=%h din=%h, expected 0 0 00", mem_control, mem_address, mem_data_in);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_ideal();
        run_check(8'h00, 0, 3'd0, 1'b0, 1'b0, "ideal_seed00");
    endtask

    task automatic test_stuck_bit();
        run_check(8'h00, 1, 3'd3, 1'b0, 1'b0, "stuck_bit3");
        n_cmp++;
        if (error_count !== 6'd16 || first_fail_addr !== 4'd8 || first_fail_phase !== 1'b0 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_bit3_const: ec=%0d ffa=%0d ffp=%b pass=%b, expected 16 8 0 0",
                     error_count, first_fail_addr, first_fail_phase, pass);
        end
    endtask

    task automatic test_addr_tie();
        run_check(8'h00, 2, 3'd0, 1'b1, 1'b0, "addr0_tied1");
        n_cmp++;
        if (error_count !== 6'd16 || first_fail_addr !== 4'd0 || first_fail_phase !== 1'b0) begin
            n_fail++;
            $display("FAIL addr0_tied1_const: ec=%0d ffa=%0d ffp=%b, expected 16 0 0",
                     error_count, first_fail_addr, first_fail_phase);
        end
    endtask

    task automatic test_reset_mid_run();
        int exp_ec;
        mode = 1; fbit = 3'd3; fval = 1'b0;
        seed = 8'h08;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        exp_ec = 0;
        for (int a = 0; a < 3; a++) if (((8 + a) & 8) != 0) exp_ec++;
        n_cmp++;
        if (error_count !== 6'(exp_ec)) begin
            n_fail++;
            $display("FAIL midrun_partial_ec: ec=%0d, expected %0d", error_count, exp_ec);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || error_count !== '0 || mem_control !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: busy=%b done=%b ec=%0d ctrl=%b, expected 0 0 0 0",
                     busy, done, error_count, mem_control);
        end
        run_check(8'($urandom), 0, 3'd0, 1'b0, 1'b0, "after_midrun_reset");
    endtask

    task automatic test_start_held();
        run_check(8'h00, 1, 3'd3, 1'b0, 1'b1, "held_stuck");
        run_check(8'hA5, 0, 3'd0, 1'b0, 1'b0, "held_then_a5");
        n_cmp++;
        if (pass !== 1'b1 || error_count !== '0) begin
            n_fail++;
            $display("FAIL a5_pass: pass=%b ec=%0d, expected 1 0", pass, error_count);
        end
    endtask

    task automatic test_back_to_back();
        int md;
        for (int r = 0; r < 8; r++) begin
            md = int'($urandom_range(0, 2));
            run_check(8'($urandom), md, (md == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'b0, $sformatf("random_%0d_mode%0d", r, md));
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        seed  = '0;
        test_reset();
        test_ideal();
        test_stuck_bit();
        test_addr_tie();
        test_reset_mid_run();
        test_start_held();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
